regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised general-purpose register file for the pipelined core, successor to the single-cycle register file.
- Adds write-to-read bypass, hardwired-zero register 0, and asynchronous reset of all registers.
- Adds an in-flight scoreboard (busy bit per register) that produces an issue stall for RAW/WAW hazards, plus a synchronous flush.
- Sits between decode/issue (read ports, issue request) and writeback (write port).

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, register index width; NREGS = 2**ADDR_W
ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports and used to clear hazards

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
Read_reg01  in  ADDR_W  read port 1 index (rs1)
Read_reg02  in  ADDR_W  read port 2 index (rs2)
Read_data01  out  DATA_W  read port 1 data, combinational
Read_data02  out  DATA_W  read port 2 data, combinational
write_signal  in  1  writeback enable
Write_reg  in  ADDR_W  writeback index (rd)
Write_data  in  DATA_W  writeback data
iss_valid  in  1  decode presents an instruction for issue
iss_rs1_en  in  1  instruction reads Read_reg01
iss_rs2_en  in  1  instruction reads Read_reg02
iss_rd_en  in  1  instruction will write iss_rd
iss_rd  in  ADDR_W  destination of issuing instruction
flush  in  1  synchronous clear of all busy bits
stall  out  1  issue blocked this cycle, combinational
pending  out  ADDR_W+1  number of busy registers, registered

Behaviour:
- Reset (async, rst=1): all NREGS registers = 0, all busy bits = 0, pending = 0. Read outputs follow the combinational rules with zeroed state. State is held while rst is high. Release is synchronous to the next clk edge.
- Write: at posedge, if write_signal, registers[Write_reg] <= Write_data. Suppressed when ZERO_REG and Write_reg == 0.
- Read (combinational), for each port p:
  - ZERO_REG and addr == 0 -> 0.
  - Else if BYPASS, write_signal and Write_reg == addr -> Write_data.
  - Else registers[addr].
- Zero latency for reads. A written value is visible through the array from the cycle after the write edge.
- Effective write: wb = write_signal & !(ZERO_REG & Write_reg == 0).
- Busy-hit for port p: busy[addr_p] & !(BYPASS & wb & Write_reg == addr_p). Register 0 is never busy when ZERO_REG.
- Issue outputs:
  - WAW: iss_rd_en & busy[iss_rd] & !(wb & Write_reg == iss_rd).
  - stall = iss_valid & ((iss_rs1_en & hit1) | (iss_rs2_en & hit2) | WAW).
  - With BYPASS = 0, a same-cycle writeback does not clear a read hazard; the instruction stalls one extra cycle.
- Issue accepted = iss_valid & !stall.
- Scoreboard update at posedge, in priority order:
  1. flush: all busy <= 0. Issue set and wb clear ignored. Register write still occurs.
  2. Otherwise, wb clears busy[Write_reg].
  3. Otherwise, issue accepted & iss_rd_en & iss_rd != 0 (when ZERO_REG) sets busy[iss_rd].
  - Set and clear on the same index in the same cycle: set wins (new producer in flight).
- pending is the registered popcount of the busy vector after each update. It saturates naturally at NREGS (or NREGS-1 with ZERO_REG).
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- stall never depends on itself. There is no combinational path from stall to any input.
- Reset asserted mid-operation clears the registers and scoreboard immediately, regardless of clk.

Test Plan:
- Reset then read: rst=1 with no clk, release; Read_reg01=5, Read_reg02=31 -> Read_data01=0, Read_data02=0, pending=0, stall=0.
- Write/read and zero register: write x3=0xDEADBEEF, then write x0=0x12345678; next cycle read x3, x0 -> 0xDEADBEEF, 0x00000000.
- Bypass: write_signal=1, Write_reg=7, Write_data=0xA5A5A5A5 while Read_reg02=7 in the same cycle -> Read_data02=0xA5A5A5A5 before the edge.
- RAW stall:
  - Cycle 0: issue iss_rd=4 accepted -> pending=1.
  - Cycle 1: iss_valid, iss_rs1_en, Read_reg01=4 -> stall=1.
  - Cycle 2: writeback x4 -> stall=0 in that cycle (BYPASS=1), pending=0 after the edge.
- Set-wins and WAW: busy x9; in the same cycle writeback x9 and accept a new issue with iss_rd=9 -> busy[9] stays 1, pending=1. A following issue writing x9 -> stall=1.
- Flush and async reset: busy x2, x5, x6 -> pending=3. Then:
  - flush=1 with a concurrent issue iss_rd=8 -> pending=0.
  - Mid-stream rst pulse between edges -> all registers read 0 and pending=0 immediately.

Source files
------------

// File: rtl/regfile_sb.sv
// Register file with hardwired-zero x0, writeback-to-read bypass and a per-register
// busy scoreboard that stalls issue on RAW/WAW hazards.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] Read_reg01,
    input  logic [ADDR_W-1:0] Read_reg02,
    output logic [DATA_W-1:0] Read_data01,
    output logic [DATA_W-1:0] Read_data02,
    input  logic              write_signal,
    input  logic [ADDR_W-1:0] Write_reg,
    input  logic [DATA_W-1:0] Write_data,
    input  logic              iss_valid,
    input  logic              iss_rs1_en,
    input  logic              iss_rs2_en,
    input  logic              iss_rd_en,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              flush,
    output logic              stall,
    output logic [ADDR_W:0]   pending
);
    localparam int   NREGS = 2 ** ADDR_W;
    localparam logic ZR    = (ZERO_REG != 0);
    localparam logic BP    = (BYPASS != 0);

    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_nxt;
    logic [ADDR_W:0]   busy_cnt;
    logic              wb;
    logic              hit1;
    logic              hit2;
    logic              waw;
    logic              accept;

    assign wb = write_signal & ~(ZR & (Write_reg == '0));

    assign Read_data01 = (ZR && Read_reg01 == '0) ? '0 :
                         (BP && write_signal && Write_reg == Read_reg01) ? Write_data :
                         regs[Read_reg01];
    assign Read_data02 = (ZR && Read_reg02 == '0) ? '0 :
                         (BP && write_signal && Write_reg == Read_reg02) ? Write_data :
                         regs[Read_reg02];

    // A same-cycle writeback resolves a read hazard only when the data is forwarded.
    assign hit1 = busy[Read_reg01] & ~(BP & wb & (Write_reg == Read_reg01));
    assign hit2 = busy[Read_reg02] & ~(BP & wb & (Write_reg == Read_reg02));
    assign waw  = iss_rd_en & busy[iss_rd] & ~(wb & (Write_reg == iss_rd));

    // Issue handshake: iss_valid is the request, ~stall is the ready; an instruction
    // is accepted on a cycle with iss_valid=1 and stall=0. stall depends only on inputs and state.
    assign stall  = iss_valid & ((iss_rs1_en & hit1) | (iss_rs2_en & hit2) | waw);
    assign accept = iss_valid & ~stall;

    always_comb begin
        busy_nxt = busy;
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (wb)
                busy_nxt[Write_reg] = 1'b0;
            // Set follows clear so a new producer on the same index wins.
            if (accept && iss_rd_en && !(ZR && iss_rd == '0))
                busy_nxt[iss_rd] = 1'b1;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NREGS; i++)
            busy_cnt = busy_cnt + (ADDR_W+1)'(busy_nxt[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
        end else if (wb) begin
            regs[Write_reg] <= Write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy    <= '0;
            pending <= '0;
        end else begin
            busy    <= busy_nxt;
            pending <= busy_cnt;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a behavioural register/scoreboard model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_regfile_sb;
    logic        clk;
    logic        rst;
    logic [4:0]  Read_reg01;
    logic [4:0]  Read_reg02;
    logic [31:0] Read_data01;
    logic [31:0] Read_data02;
    logic        write_signal;
    logic [4:0]  Write_reg;
    logic [31:0] Write_data;
    logic        iss_valid;
    logic        iss_rs1_en;
    logic        iss_rs2_en;
    logic        iss_rd_en;
    logic [4:0]  iss_rd;
    logic        flush;
    logic        stall;
    logic [5:0]  pending;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    regfile_sb dut (
        .clk(clk), .rst(rst),
        .Read_reg01(Read_reg01), .Read_reg02(Read_reg02),
        .Read_data01(Read_data01), .Read_data02(Read_data02),
        .write_signal(write_signal), .Write_reg(Write_reg), .Write_data(Write_data),
        .iss_valid(iss_valid), .iss_rs1_en(iss_rs1_en), .iss_rs2_en(iss_rs2_en),
        .iss_rd_en(iss_rd_en), .iss_rd(iss_rd),
        .flush(flush), .stall(stall), .pending(pending)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // behavioural model: register contents and the set of in-flight destinations
    logic [31:0] m_regs [32];
    bit          m_busy [32];

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (write_signal && Write_reg == a) return Write_data;
        return m_regs[a];
    endfunction

    function automatic bit retiring(input logic [4:0] a);
        return write_signal && Write_reg == a && a != 5'd0;
    endfunction

    function automatic bit model_stall();
        bit src1_wait, src2_wait, dst_wait;
        src1_wait = iss_rs1_en && m_busy[Read_reg01] && !retiring(Read_reg01);
        src2_wait = iss_rs2_en && m_busy[Read_reg02] && !retiring(Read_reg02);
        dst_wait  = iss_rd_en && m_busy[iss_rd] && !retiring(iss_rd);
        return iss_valid && (src1_wait || src2_wait || dst_wait);
    endfunction

    function automatic int model_pending();
        int n = 0;
        foreach (m_busy[i]) if (m_busy[i]) n++;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_regs[i] <= 32'd0;
                m_busy[i] <= 1'b0;
            end
        end else begin
            if (write_signal && Write_reg != 5'd0)
                m_regs[Write_reg] <= Write_data;
            if (flush) begin
                for (int i = 0; i < 32; i++) m_busy[i] <= 1'b0;
            end else begin
                if (retiring(Write_reg)) m_busy[Write_reg] <= 1'b0;
                if (iss_valid && !model_stall() && iss_rd_en && iss_rd != 5'd0)
                    m_busy[iss_rd] <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // compare process: every falling edge, outputs against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("model_rd1", Read_data01, model_read(Read_reg01));
            chk("model_rd2", Read_data02, model_read(Read_reg02));
            chk("model_stall", {31'd0, stall}, {31'd0, model_stall()});
            chk("model_pending", {26'd0, pending}, 32'(model_pending()));
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        write_signal = 1'b0; Write_reg = '0; Write_data = '0;
        iss_valid = 1'b0; iss_rs1_en = 1'b0; iss_rs2_en = 1'b0;
        iss_rd_en = 1'b0; iss_rd = '0; flush = 1'b0;
    endtask

    task automatic do_write(input logic [4:0] r, input logic [31:0] d);
        write_signal = 1'b1; Write_reg = r; Write_data = d;
    endtask

    task automatic do_issue(input logic [4:0] rd);
        iss_valid = 1'b1; iss_rd_en = 1'b1; iss_rd = rd;
    endtask

    initial begin
        rst = 1'b0;
        Read_reg01 = '0; Read_reg02 = '0;
        idle();
        #1 rst = 1'b1;
        Read_reg01 = 5'd5; Read_reg02 = 5'd31;
        #1;
        chk("reset_rd1", Read_data01, 32'd0);
        chk("reset_rd2", Read_data02, 32'd0);
        chk("reset_pending", {26'd0, pending}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        tick();
        rst = 1'b0;

        // write/read and zero register
        tick(); do_write(5'd3, 32'hDEADBEEF);
        tick(); do_write(5'd0, 32'h12345678);
        tick(); idle(); Read_reg01 = 5'd3; Read_reg02 = 5'd0;
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h00000000);
        @(negedge clk);
        chk("read_x3", Read_data01, exp_q.pop_front());
        chk("read_x0", Read_data02, exp_q.pop_front());

        // bypass
        tick(); do_write(5'd7, 32'hA5A5A5A5); Read_reg02 = 5'd7;
        @(negedge clk);
        chk("bypass_rd2", Read_data02, 32'hA5A5A5A5);

        // RAW stall resolved by writeback
        tick(); idle(); do_issue(5'd4);
        @(negedge clk);
        chk("raw_issue_stall", {31'd0, stall}, 32'd0);
        tick(); idle(); iss_valid = 1'b1; iss_rs1_en = 1'b1; Read_reg01 = 5'd4;
        @(negedge clk);
        chk("raw_pending", {26'd0, pending}, 32'd1);
        chk("raw_stall", {31'd0, stall}, 32'd1);
        tick(); do_write(5'd4, 32'h00000044);
        @(negedge clk);
        chk("raw_bypass_stall", {31'd0, stall}, 32'd0);
        chk("raw_bypass_rd1", Read_data01, 32'h00000044);
        tick(); idle();
        @(negedge clk);
        chk("raw_pending_after", {26'd0, pending}, 32'd0);

        // set wins over clear, then WAW
        tick(); do_issue(5'd9);
        tick(); do_write(5'd9, 32'h99); do_issue(5'd9);
        @(negedge clk);
        chk("setwin_stall", {31'd0, stall}, 32'd0);
        tick(); idle(); do_issue(5'd9);
        @(negedge clk);
        chk("setwin_pending", {26'd0, pending}, 32'd1);
        chk("waw_stall", {31'd0, stall}, 32'd1);
        tick(); idle(); do_write(5'd9, 32'h9A);
        tick(); idle();
        @(negedge clk);
        chk("waw_cleared", {26'd0, pending}, 32'd0);

        // flush with concurrent issue and register write
        tick(); do_issue(5'd2);
        tick(); do_issue(5'd5);
        tick(); do_issue(5'd6);
        tick(); idle();
        @(negedge clk);
        chk("flush_pre_pending", {26'd0, pending}, 32'd3);
        tick(); do_issue(5'd8); flush = 1'b1; do_write(5'd10, 32'h10101010);
        tick(); idle(); Read_reg01 = 5'd10; Read_reg02 = 5'd3;
        @(negedge clk);
        chk("flush_pending", {26'd0, pending}, 32'd0);
        chk("flush_write_kept", Read_data01, 32'h10101010);

        // asynchronous reset between edges
        tick(); do_issue(5'd12);
        tick(); idle();
        @(negedge clk);
        chk("async_pre_pending", {26'd0, pending}, 32'd1);
        tick();
        #1 rst = 1'b1;
        #1;
        chk("async_rd1", Read_data01, 32'd0);
        chk("async_rd2", Read_data02, 32'd0);
        chk("async_pending", {26'd0, pending}, 32'd0);
        rst = 1'b0;
        tick(); idle();
        @(negedge clk);
        chk("async_after_rd1", Read_data01, 32'd0);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
